// File: rtl/inst_load_ctrl.sv
// Boot/program loader: streams words into instruction memory, holds the core in reset until done.
// Optional checksum verification of the loaded image is compiled in with `define CHECKSUM_EN.
module inst_load_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 1024,
  parameter int BASE_ADDR = 0,
  parameter int RST_HOLD  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MEM_INST_ENB,
  input  logic [DATA_W-1:0] MEM_INST,
  input  logic              LOAD_LAST,
  input  logic              RELOAD,
  output logic              IMEM_WE,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  output logic [DATA_W-1:0] IMEM_WDATA,
  output logic              CPU_RST,
  output logic              LOAD_DONE,
  output logic              LOAD_ERR,
  output logic [ADDR_W:0]   WORD_COUNT
);

  localparam int CW = ADDR_W + 1;
  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  localparam logic [CW-1:0]     DEPTH_C   = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C    = ADDR_W'(BASE_ADDR);
  localparam logic [HW-1:0]     HOLD_LAST = HW'(RST_HOLD - 1);

  if (longint'(BASE_ADDR) + longint'(DEPTH) > (longint'(1) << ADDR_W))
  begin : g_span_chk
    $error("inst_load_ctrl: BASE_ADDR+DEPTH exceeds address space");
  end

  if (RST_HOLD < 1) begin : g_hold_chk
    $error("inst_load_ctrl: RST_HOLD must be at least 1");
  end

`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {
    S_LOAD, S_HOLD, S_RUN, S_ERR, S_CHK
  } state_t;
`else
  typedef enum logic [1:0] {
    S_LOAD, S_HOLD, S_RUN, S_ERR
  } state_t;
`endif

  state_t state_q, state_d;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;
`ifdef CHECKSUM_EN
    sum_d     = sum_q;
`endif

    // RELOAD outranks everything except RST; a same-cycle strobe is dropped.
    if (RELOAD) begin
      state_d   = S_LOAD;
      cnt_d     = '0;
      hold_d    = '0;
      cpu_rst_d = 1'b1;
      done_d    = 1'b0;
      err_d     = 1'b0;
`ifdef CHECKSUM_EN
      sum_d     = '0;
`endif
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (MEM_INST_ENB) begin
            if (cnt_q == DEPTH_C) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else begin
              we_d    = 1'b1;
              addr_d  = BASE_C + cnt_q[ADDR_W-1:0];
              wdata_d = MEM_INST;
              cnt_d   = cnt_q + 1'b1;
`ifdef CHECKSUM_EN
              sum_d   = sum_q + MEM_INST;
`endif
              if (LOAD_LAST) begin
                hold_d  = '0;
`ifdef CHECKSUM_EN
                state_d = S_CHK;
`else
                state_d = S_HOLD;
`endif
              end
            end
          end
        end
        S_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_d   = S_RUN;
            cpu_rst_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        S_RUN: begin
          cpu_rst_d = 1'b0;
        end
        S_ERR: begin
          cpu_rst_d = 1'b1;
          done_d    = 1'b0;
        end
`ifdef CHECKSUM_EN
        // Checksum word is compared only, never written or counted.
        S_CHK: begin
          if (MEM_INST_ENB) begin
            if (MEM_INST == sum_q) begin
              state_d = S_HOLD;
              hold_d  = '0;
            end else begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end
          end
        end
`endif
        default: begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_LOAD;
      cnt_q     <= '0;
      hold_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= BASE_C;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign IMEM_WE    = we_q;
  assign IMEM_ADDR  = addr_q;
  assign IMEM_WDATA = wdata_q;
  assign CPU_RST    = cpu_rst_q;
  assign LOAD_DONE  = done_q;
  assign LOAD_ERR   = err_q;
  assign WORD_COUNT = cnt_q;

endmodule

// File: tb/tb_inst_load_ctrl.sv
// Scoreboard bench for inst_load_ctrl: expected writes are queued at stimulus time,
// a negedge monitor pops and compares them; status is checked against a load-level model.
module tb_inst_load_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 4;
  localparam int BASE  = 'h100;
  localparam int RH    = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          MEM_INST_ENB = 1'b0;
  logic [DW-1:0] MEM_INST = '0;
  logic          LOAD_LAST = 1'b0;
  logic          RELOAD = 1'b0;
  logic          IMEM_WE;
  logic [AW-1:0] IMEM_ADDR;
  logic [DW-1:0] IMEM_WDATA;
  logic          CPU_RST;
  logic          LOAD_DONE;
  logic          LOAD_ERR;
  logic [AW:0]   WORD_COUNT;

  inst_load_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH),
    .BASE_ADDR(BASE), .RST_HOLD(RH)
  ) dut (
    .CLK(CLK), .RST(RST),
    .MEM_INST_ENB(MEM_INST_ENB), .MEM_INST(MEM_INST),
    .LOAD_LAST(LOAD_LAST), .RELOAD(RELOAD),
    .IMEM_WE(IMEM_WE), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_WDATA(IMEM_WDATA), .CPU_RST(CPU_RST),
    .LOAD_DONE(LOAD_DONE), .LOAD_ERR(LOAD_ERR),
    .WORD_COUNT(WORD_COUNT)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int unsigned   at;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  armed = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Write monitor
  wr_t mon_e;
  always @(negedge CLK) begin
    if (armed) begin
      if (IMEM_WE !== 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {63'd0, IMEM_WE}, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("write_addr", {48'd0, IMEM_ADDR}, {48'd0, mon_e.addr});
          chk("write_data", {32'd0, IMEM_WDATA}, {32'd0, mon_e.data});
          chk("write_cycle", {32'd0, cyc}, {32'd0, mon_e.at});
        end
      end else if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
        chk("missing_write", {63'd0, IMEM_WE}, 64'd1);
        mon_e = exp_q.pop_front();
      end
    end
  end

  // Load-level reference model
  localparam int P_LOAD = 0;
  localparam int P_CHK  = 1;
  localparam int P_HOLD = 2;
  localparam int P_ERR  = 3;

  int            m_phase = P_LOAD;
  int unsigned   m_cnt = 0;
  logic [DW-1:0] m_sum = '0;
  int unsigned   m_run_at = 0;

  function automatic bit m_running();
    return (m_phase == P_HOLD) && (cyc >= m_run_at);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_status();
    bit run;
    run = m_running();
    chk("cpu_rst", {63'd0, CPU_RST}, {63'd0, !run});
    chk("load_done", {63'd0, LOAD_DONE}, {63'd0, run});
    chk("load_err", {63'd0, LOAD_ERR}, {63'd0, m_phase == P_ERR});
    chk("word_count", {47'd0, WORD_COUNT}, {32'd0, m_cnt});
  endtask

  task automatic model_clear();
    m_phase = P_LOAD;
    m_cnt   = 0;
    m_sum   = '0;
  endtask

  task automatic send_word(input logic [DW-1:0] w, input bit last);
    wr_t e;
    MEM_INST     = w;
    MEM_INST_ENB = 1'b1;
    LOAD_LAST    = last;
    case (m_phase)
      P_LOAD: begin
        if (m_cnt == DEPTH) begin
          m_phase = P_ERR;
        end else begin
          e.addr = AW'(BASE + m_cnt);
          e.data = w;
          e.at   = cyc + 1;
          exp_q.push_back(e);
          m_cnt++;
          m_sum = m_sum + w;
          if (last) begin
`ifdef CHECKSUM_EN
            m_phase = P_CHK;
`else
            m_phase  = P_HOLD;
            m_run_at = cyc + 1 + RH;
`endif
          end
        end
      end
      P_CHK: begin
        if (w == m_sum) begin
          m_phase  = P_HOLD;
          m_run_at = cyc + 1 + RH;
        end else begin
          m_phase = P_ERR;
        end
      end
      default: ;
    endcase
    tick();
    MEM_INST_ENB = 1'b0;
    LOAD_LAST    = 1'b0;
    check_status();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_status();
    end
  endtask

  task automatic do_reset();
    RST          = 1'b1;
    MEM_INST_ENB = 1'b0;
    LOAD_LAST    = 1'b0;
    RELOAD       = 1'($urandom % 2);
    tick();
    RST    = 1'b0;
    RELOAD = 1'b0;
    armed  = 1'b1;
    model_clear();
    chk("rst_we", {63'd0, IMEM_WE}, 64'd0);
    chk("rst_addr", {48'd0, IMEM_ADDR}, 64'(BASE));
    chk("rst_wdata", {32'd0, IMEM_WDATA}, 64'd0);
    check_status();
  endtask

  task automatic do_reload(input bit strobe);
    RELOAD = 1'b1;
    if (strobe) begin
      MEM_INST_ENB = 1'b1;
      MEM_INST     = $urandom;
      LOAD_LAST    = 1'($urandom % 2);
    end
    tick();
    RELOAD       = 1'b0;
    MEM_INST_ENB = 1'b0;
    LOAD_LAST    = 1'b0;
    model_clear();
    check_status();
  endtask

  task automatic send_checksum(input bit good);
    if (m_phase == P_CHK)
      send_word(good ? m_sum : (m_sum ^ 32'h1), 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Basic three-word load, then hold, then run
    send_word(32'h11, 1'b0);
    send_word(32'h22, 1'b0);
    send_word(32'h33, 1'b1);
    send_checksum(1'b1);
    idle(RH + 1);

    // Strobes in RUN are ignored
    send_word(32'hDEAD, 1'b1);
    idle(2);

    // Reload with a dropped same-cycle strobe, then a two-word program
    do_reload(1'b1);
    send_word($urandom, 1'b0);
    send_word($urandom, 1'b1);
    send_checksum(1'b1);
    idle(RH + 1);

    // Overflow: DEPTH+1 words without LAST, then ignored strobes in ERR
    do_reload(1'b0);
    for (int i = 0; i < DEPTH + 1; i++) send_word($urandom, 1'b0);
    send_word($urandom, 1'b1);
    idle(2);

    // Reset mid-load, then a fresh load from BASE
    do_reload(1'b0);
    send_word($urandom, 1'b0);
    send_word($urandom, 1'b0);
    do_reset();
    send_word($urandom, 1'b0);
    send_word($urandom, 1'b0);
    send_word($urandom, 1'b1);
    send_checksum(1'b1);
    idle(RH + 1);

`ifdef CHECKSUM_EN
    do_reload(1'b0);
    send_word(32'd1, 1'b0);
    send_word(32'd2, 1'b0);
    send_word(32'd3, 1'b1);
    send_word(32'd6, 1'b0);
    idle(RH + 1);
    do_reload(1'b0);
    send_word(32'd1, 1'b0);
    send_word(32'd2, 1'b0);
    send_word(32'd3, 1'b1);
    send_word(32'd7, 1'b0);
    idle(2);
`endif

    // Randomized loads
    for (int it = 0; it < 40; it++) begin
      int n;
      if ($urandom % 4 == 0) do_reset();
      else do_reload(1'($urandom % 2));
      n = $urandom_range(1, DEPTH + 1);
      for (int i = 0; i < n; i++) begin
        bit last;
        last = (i == n - 1) && ($urandom % 4 != 0);
        send_word($urandom, last);
        if ($urandom % 3 == 0) idle($urandom_range(1, 2));
      end
      send_checksum(1'($urandom % 2));
      idle(RH + 1);
      if ($urandom % 2 == 0) send_word($urandom, 1'($urandom % 2));
    end

    idle(3);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
